// File: rtl/riva_pkg.sv
// Shared RIVA matrix-LSU types: response record, tracker entry and merger FSM states.
package riva_pkg;

   localparam int unsigned MLSU_REQ_ID_W = 8;
   localparam int unsigned MLEN_W        = 4;

   typedef struct packed {
      logic [MLSU_REQ_ID_W-1:0] reqId;
      logic                     isLoad;
      logic                     err;
   } mlsu_resp_t;

   typedef struct packed {
      logic [MLSU_REQ_ID_W-1:0] req_id;
      logic [MLEN_W-1:0]        tile;
      logic                     is_load;
   } mlsu_trk_entry_t;

   typedef enum logic {
      S_IDLE    = 1'b0,
      S_COLLECT = 1'b1
   } mlsu_mrg_state_e;

endpackage

// File: rtl/mlsu_resp_merger_fifo.sv
// Synchronous tracker FIFO of split-request entries; push and pop may coincide.
module SyncFifo
   import riva_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            push_i,
   input  mlsu_trk_entry_t data_i,
   input  logic            pop_i,
   output mlsu_trk_entry_t data_o,
   output logic            full_o,
   output logic            empty_o,
   output logic            single_o
);

   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);

   mlsu_trk_entry_t  mem_r [DEPTH];
   logic [PTR_W-1:0] wr_ptr_r;
   logic [PTR_W-1:0] rd_ptr_r;
   logic [CNT_W-1:0] count_r;
   logic             push_ok_s;
   logic             pop_ok_s;

   function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] ptr);
      if (ptr == PTR_W'(DEPTH - 1)) begin
         return {PTR_W{1'b0}};
      end else begin
         return ptr + PTR_W'(1'b1);
      end
   endfunction

   assign full_o    = (count_r == CNT_W'(DEPTH));
   assign empty_o   = (count_r == {CNT_W{1'b0}});
   assign single_o  = (count_r == CNT_W'(1'b1));
   assign push_ok_s = push_i && !full_o;
   assign pop_ok_s  = pop_i && !empty_o;
   assign data_o    = mem_r[rd_ptr_r];

   // Entry storage: data needs no reset, validity lives in count_r.
   always_ff @(posedge clk_i) begin
      if (push_ok_s) begin
         mem_r[wr_ptr_r] <= data_i;
      end
   end

   // Pointers and occupancy.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr_r <= {PTR_W{1'b0}};
         rd_ptr_r <= {PTR_W{1'b0}};
         count_r  <= {CNT_W{1'b0}};
      end else begin
         if (push_ok_s) begin
            wr_ptr_r <= ptr_next(wr_ptr_r);
         end
         if (pop_ok_s) begin
            rd_ptr_r <= ptr_next(rd_ptr_r);
         end
         case ({push_ok_s, pop_ok_s})
            2'b10:   count_r <= count_r + CNT_W'(1'b1);
            2'b01:   count_r <= count_r - CNT_W'(1'b1);
            default: count_r <= count_r;
         endcase
      end
   end

endmodule

// File: rtl/mlsu_resp_merger.sv
// Merges per-tile MLSU completions back into one in-order response per original request.
module mlsu_resp_merger
   import riva_pkg::*;
#(
   parameter int unsigned DEPTH  = 4,
   parameter int unsigned ID_W   = MLSU_REQ_ID_W,
   parameter int unsigned TILE_W = MLEN_W
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              alloc_valid_i,
   output logic              alloc_ready_o,
   input  logic [ID_W-1:0]   alloc_req_id_i,
   input  logic [TILE_W-1:0] alloc_tile_i,
   input  logic              alloc_is_load_i,
   input  logic              cpl_valid_i,
   output logic              cpl_ready_o,
   input  logic              cpl_err_i,
   output logic              resp_valid_o,
   input  logic              resp_ready_i,
   output logic [ID_W-1:0]   resp_req_id_o,
   output logic              resp_is_load_o,
   output logic              resp_err_o
);

   mlsu_mrg_state_e   state_r, state_s;
   logic [TILE_W-1:0] cnt_r;
   logic              err_r;
   mlsu_resp_t        resp_r;
   logic              resp_valid_r;

   mlsu_trk_entry_t   alloc_entry_s;
   mlsu_trk_entry_t   head_s;
   logic              fifo_full_s, fifo_empty_s, fifo_single_s;
   logic              push_s, cpl_ready_s, cpl_fire_s, last_s;
   logic [TILE_W:0]   cnt_inc_s;

   // A zero tile count is illegal upstream; it is tracked as a single tile.
   function automatic logic [TILE_W-1:0] eff_tile(input logic [TILE_W-1:0] tile);
      if (tile == {TILE_W{1'b0}}) begin
         return TILE_W'(1'b1);
      end else begin
         return tile;
      end
   endfunction

   assign push_s                = alloc_valid_i && !fifo_full_s;
   assign alloc_entry_s.req_id  = alloc_req_id_i;
   assign alloc_entry_s.tile    = eff_tile(alloc_tile_i);
   assign alloc_entry_s.is_load = alloc_is_load_i;

   SyncFifo #(.DEPTH(DEPTH)) u_trk_fifo (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .push_i   (push_s),
      .data_i   (alloc_entry_s),
      .pop_i    (last_s),
      .data_o   (head_s),
      .full_o   (fifo_full_s),
      .empty_o  (fifo_empty_s),
      .single_o (fifo_single_s)
   );

   // Next state, completion ready and last-completion detect.
   always_comb begin
      state_s     = state_r;
      cpl_ready_s = 1'b0;
      case (state_r)
         S_IDLE: begin
            if (push_s || !fifo_empty_s) begin
               state_s = S_COLLECT;
            end else begin
               state_s = S_IDLE;
            end
         end
         S_COLLECT: begin
            cpl_ready_s = !resp_valid_r || resp_ready_i;
            if (cpl_valid_i && cpl_ready_s && fifo_single_s && !push_s &&
                ({1'b0, cnt_r} + (TILE_W+1)'(1'b1) == {1'b0, head_s.tile})) begin
               state_s = S_IDLE;
            end else begin
               state_s = S_COLLECT;
            end
         end
         default: begin
            state_s = S_IDLE;
         end
      endcase
   end

   // Widened increment so a tile count of all-ones still compares correctly.
   assign cnt_inc_s  = {1'b0, cnt_r} + (TILE_W+1)'(1'b1);
   assign cpl_fire_s = cpl_valid_i && cpl_ready_s;
   assign last_s     = cpl_fire_s && (cnt_inc_s == {1'b0, head_s.tile});

   // FSM state, head completion count and sticky error.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_r <= S_IDLE;
         cnt_r   <= {TILE_W{1'b0}};
         err_r   <= 1'b0;
      end else begin
         state_r <= state_s;
         if (last_s) begin
            cnt_r <= {TILE_W{1'b0}};
            err_r <= 1'b0;
         end else if (cpl_fire_s) begin
            cnt_r <= cnt_inc_s[TILE_W-1:0];
            err_r <= err_r | cpl_err_i;
         end
      end
   end

   // Response register; a new response may overwrite one leaving in the same cycle.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         resp_r       <= '{reqId: {MLSU_REQ_ID_W{1'b0}}, isLoad: 1'b0, err: 1'b0};
         resp_valid_r <= 1'b0;
      end else if (last_s) begin
         resp_r       <= '{reqId: head_s.req_id, isLoad: head_s.is_load, err: err_r | cpl_err_i};
         resp_valid_r <= 1'b1;
      end else if (resp_valid_r && resp_ready_i) begin
         resp_valid_r <= 1'b0;
      end
   end

   assign alloc_ready_o  = !fifo_full_s;
   assign cpl_ready_o    = cpl_ready_s;
   assign resp_valid_o   = resp_valid_r;
   assign resp_req_id_o  = resp_r.reqId;
   assign resp_is_load_o = resp_r.isLoad;
   assign resp_err_o     = resp_r.err;

   a_tile_nonzero: assert property (@(posedge clk_i) disable iff (rst_i)
      !(alloc_valid_i && (alloc_tile_i == {TILE_W{1'b0}})));

   a_cnt_bound: assert property (@(posedge clk_i) disable iff (rst_i)
      (state_r == S_COLLECT) |-> (cnt_r < head_s.tile));

endmodule

// File: doc/mlsu_resp_merger.md
# mlsu_resp_merger

Matrix LSU response merger: the return-path counterpart of the MLSU request pre-decoder. The pre-decoder splits one MLSU request into `tile` row/column pre-decoded requests. This block records each split request, counts the per-tile completions coming back from the memory side, and emits exactly one MLSU response per original request. Responses are emitted in the original order, with a sticky error flag.

## Interface
- `DEPTH`, default 4: maximum number of outstanding split requests tracked.
- `ID_W`, default `riva_pkg::MLSU_REQ_ID_W`: width of the request ID.
- `TILE_W`, default `riva_pkg::MLEN_W`: width of the tile count; it is the same type as the pre-decoder's tile field.
- `clk_i  in  1`: the single clock.
- `rst_i  in  1`: synchronous, active-high reset.
- `alloc_valid_i  in  1`: the pre-decoder has accepted a request and registers it here.
- `alloc_ready_o  out  1`: the tracker FIFO has a free entry.
- `alloc_req_id_i  in  ID_W`: ID of the request being registered.
- `alloc_tile_i  in  TILE_W`: number of pre-decoded requests the request was split into.
- `alloc_is_load_i  in  1`: 1 for a load, 0 for a store.
- `cpl_valid_i  in  1`: one completion for a pre-decoded request. Completions arrive in issue order.
- `cpl_ready_o  out  1`: the completion is accepted.
- `cpl_err_i  in  1`: that tile-line faulted.
- `resp_valid_o  out  1`: a merged response is pending.
- `resp_ready_i  in  1`: the downstream consumer accepts the response.
- `resp_req_id_o  out  ID_W`: ID of the completed request.
- `resp_is_load_o  out  1`: the `is_load` of the completed request.
- `resp_err_o  out  1`: OR of `cpl_err_i` over all of the request's completions.

## Operation
- **Tracker FIFO:** DEPTH entries of {req_id, tile, is_load}.
  - `alloc_ready_o = !full`.
  - There is no enqueue-to-head bypass. A newly allocated entry becomes the head one cycle after its handshake, at the earliest.
  - `alloc_ready_o` does not depend on a same-cycle pop: when the FIFO is full and a pop occurs, `alloc_ready_o` is still 0 in that cycle.
- **Head state:** `cnt_r` (TILE_W bits) counts completions received for the head entry; `err_r` is the sticky error for the head.
- **FSM:**
  - S_IDLE: the FIFO is empty. Go to S_COLLECT when the FIFO becomes non-empty.
  - S_COLLECT: the head entry is valid.
    - `cpl_ready_o = !resp_valid_o || resp_ready_i`.
    - Every accepted completion sets `err_r |= cpl_err_i`.
    - If `cnt_r + 1 == head.tile` (last completion):
      - load the response register with {head.req_id, head.is_load, `err_r | cpl_err_i`};
      - pop the FIFO;
      - clear `cnt_r` and `err_r`;
      - stay in S_COLLECT if a further entry is valid after the pop, otherwise go to S_IDLE.
    - Otherwise `cnt_r` increments.
  - In S_IDLE, `cpl_ready_o = 0`. Completions that arrive with nothing outstanding are back-pressured and never dropped.
- **Response register:** `resp_valid_o` is set on the last completion and cleared on `resp_valid_o && resp_ready_i`. A set and a clear in the same cycle means a new response replaces the old one, so `resp_valid_o` stays 1.
- **Tile count of 0:** illegal. An assertion fires on `alloc_valid_i && alloc_tile_i == 0`. The RTL treats such an entry as `tile = 1`.
- **Width rules:**
  - `cnt_r + 1` is computed in TILE_W+1 bits, so the compare does not wrap when `tile = 2^TILE_W - 1`.
  - The count never exceeds `head.tile`.

## Timing
- **Reset values:** `alloc_ready_o = 1`, `cpl_ready_o = 0`, `resp_valid_o = 0`, `resp_req_id_o = 0`, `resp_is_load_o = 0`, `resp_err_o = 0`. Reset also sets the FSM to S_IDLE, `cnt_r = 0`, `err_r = 0`, and empties the FIFO.
- **Latency:**
  - Last completion handshake to `resp_valid_o = 1`: 1 cycle.
  - Allocation to earliest accepted completion: 1 cycle.
- **Throughput:** one completion per cycle. For requests with `tile = 1`, one response per cycle, provided `resp_ready_i` is held high.
- **Response holding:** while `resp_valid_o && !resp_ready_i`, all `resp_*` outputs stay stable and `cpl_ready_o = 0`.
- **Reset mid-operation:** all outstanding entries, partial counts and any pending response are discarded. There is no draining.

## Structure
- **Shared in `riva_pkg`:**
  - `mlsu_resp_t` {reqId, isLoad, err};
  - the tracker entry typedef `mlsu_trk_entry_t`;
  - `MLSU_REQ_ID_W`, reused from the request types.
- **Sub-module:** one, `SyncFifo`, a synchronous FIFO with active-high synchronous reset. It holds `mlsu_trk_entry_t` and is DEPTH deep. It provides full/empty flags; push and pop in the same cycle are legal.
- **Top level:** holds the FSM, `cnt_r`, `err_r`, the response register and the assertions.

## Test plan
- **Single request:** alloc {id=3, tile=4, load}, then 4 back-to-back completions with err=0 → exactly one response {id=3, is_load=1, err=0}, with `resp_valid_o` rising the cycle after the 4th completion.
- **Sticky error:** alloc {id=5, tile=3}, with completion errors 0, 1, 0 → one response {id=5, err=1}. A following request {id=6, tile=2} with no errors → err=0, showing the error was cleared.
- **Ordering and full FIFO:** allocate 4 requests with tiles 1, 2, 1, 3.
  - A 5th alloc sees `alloc_ready_o = 0` until the first pop.
  - Responses come out in the order id0..id3.
- **Back-pressure:** hold `resp_ready_i = 0` after the response for {id=1, tile=1} → `cpl_ready_o = 0` and outputs stay stable. Release `resp_ready_i` → the next completion is accepted in that same cycle.
- **Completion with nothing outstanding:** drive `cpl_valid_i` with the FIFO empty → `cpl_ready_o = 0` for 10 cycles. Then alloc {tile=1} → the completion is accepted 1 cycle after the allocation handshake.
- **Reset mid-operation:** with 2 outstanding entries and `cnt_r = 1`, assert `rst_i` for 1 cycle → every output is at its reset value and no stale response appears afterwards.
